prio_encoder_drain: RTL and testbench

PRIO_ENCODER_DRAIN -- requirements
Module: prio_encoder_drain

---
 rtl/prio_encoder_drain_if.sv | 25 ++
 rtl/prio_encoder_drain.sv | 135 +++++++++++++
 tb/tb_prio_encoder_drain.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/prio_encoder_drain_if.sv
// Handshake bundle for prio_encoder_drain: vector capture side and per-index drain side.
interface prio_encoder_drain_if #(
  parameter int N = 8,
  parameter int W = (N > 2) ? $clog2(N) : 1
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         msb_first;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_zero;

  modport master (
    output in_valid, in_vec, msb_first, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_zero
  );

  modport slave (
    input  in_valid, in_vec, msb_first, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_zero
  );
endinterface

// File: rtl/prio_encoder_drain.sv
// Captures a request vector and emits the index of each set bit, one beat per transfer,
// in lowest-first or highest-first order. All outputs come straight from flops.
module prio_encoder_drain #(
  parameter int N = 8,
  parameter int W = (N > 2) ? $clog2(N) : 1
) (
  input logic              clk,
  input logic              rst,
  prio_encoder_drain_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic logic [W-1:0] lsb_index(input logic [N-1:0] vec);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic [W-1:0] msb_index(input logic [N-1:0] vec);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic at_most_one(input logic [N-1:0] vec);
    return (vec & (vec - {{(N-1){1'b0}}, 1'b1})) == '0;
  endfunction

  state_t       state_r, state_s;
  logic [N-1:0] pend_r, pend_s;
  logic         mode_r, mode_s;
  logic [N-1:0] clear_mask_s;

  logic         in_ready_r, in_ready_s;
  logic         out_valid_r, out_valid_s;
  logic [W-1:0] out_idx_r, out_idx_s;
  logic         out_last_r, out_last_s;
  logic         out_zero_r, out_zero_s;

  assign clear_mask_s = {{(N-1){1'b0}}, 1'b1} << out_idx_r;

  // Next state, pending bits and mode; inputs are only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    mode_s  = mode_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s = DRAIN;
          pend_s  = bus.in_vec;
          mode_s  = bus.msb_first;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          // The registered out_idx is exactly the bit being handed over now.
          pend_s = pend_r & ~clear_mask_s;
          if (out_last_r) begin
            state_s = IDLE;
            pend_s  = '0;
          end else begin
            state_s = DRAIN;
          end
        end else begin
          pend_s = pend_r;
        end
      end
      default: begin
        state_s = IDLE;
        pend_s  = '0;
        mode_s  = 1'b0;
      end
    endcase
  end

  // Output values for the next cycle, derived from next state so outputs can be flopped.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    out_idx_s   = '0;
    out_last_s  = 1'b0;
    out_zero_s  = 1'b0;
    if (state_s == DRAIN) begin
      out_valid_s = 1'b1;
      out_idx_s   = mode_s ? msb_index(pend_s) : lsb_index(pend_s);
      out_last_s  = at_most_one(pend_s);
      out_zero_s  = (pend_s == '0);
    end else begin
      in_ready_s = 1'b1;
    end
  end

  // State, pending vector and output registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pend_r      <= '0;
      mode_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_idx_r   <= '0;
      out_last_r  <= 1'b0;
      out_zero_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      pend_r      <= pend_s;
      mode_r      <= mode_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_idx_r   <= out_idx_s;
      out_last_r  <= out_last_s;
      out_zero_r  <= out_zero_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_zero  = out_zero_r;

endmodule

// File: tb/tb_prio_encoder_drain.sv
// Directed bench for prio_encoder_drain (N = 8) with hand-computed expected beats.
module tb_prio_encoder_drain;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  prio_encoder_drain_if #(.N(8), .W(3)) bus ();

  prio_encoder_drain #(.N(8), .W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_idx"},   32'(bus.out_idx),   32'd0);
    check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    check({tag, "_out_zero"},  32'(bus.out_zero),  32'd0);
  endtask

  // Offer a vector for one cycle, then scramble the inputs so later capture would show.
  task automatic accept(input logic [7:0] vec, input logic msb);
    check("accept_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_vec    = vec;
    bus.msb_first = msb;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_vec    = 8'h3C;
    bus.msb_first = ~msb;
  endtask

  task automatic beat(input string tag, input logic [2:0] idx, input logic last, input logic zero);
    check({tag, "_valid"},    32'(bus.out_valid), 32'd1);
    check({tag, "_in_ready"}, 32'(bus.in_ready),  32'd0);
    check({tag, "_idx"},      32'(bus.out_idx),   32'(idx));
    check({tag, "_last"},     32'(bus.out_last),  32'(last));
    check({tag, "_zero"},     32'(bus.out_zero),  32'(zero));
    tick();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_vec    = 8'h00;
    bus.msb_first = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // Single bit, lowest first.
    bus.out_ready = 1'b1;
    accept(8'b0000_0100, 1'b0);
    beat("single", 3'd2, 1'b1, 1'b0);
    check_idle("single_done");

    // Three bits, both orders.
    accept(8'b1000_0101, 1'b0);
    beat("lsb0", 3'd0, 1'b0, 1'b0);
    beat("lsb1", 3'd2, 1'b0, 1'b0);
    beat("lsb2", 3'd7, 1'b1, 1'b0);
    check_idle("lsb_done");
    accept(8'b1000_0101, 1'b1);
    beat("msb0", 3'd7, 1'b0, 1'b0);
    beat("msb1", 3'd2, 1'b0, 1'b0);
    beat("msb2", 3'd0, 1'b1, 1'b0);
    check_idle("msb_done");

    // All-zero vector gives one zero beat.
    accept(8'h00, 1'b1);
    beat("zero", 3'd0, 1'b1, 1'b1);
    check_idle("zero_done");

    // Full vector drains back-to-back while in_valid toggles.
    accept(8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = i[0];
      bus.in_vec   = 8'h5A;
      beat("full", 3'(i), (i == 7) ? 1'b1 : 1'b0, 1'b0);
    end
    bus.in_valid = 1'b0;
    check_idle("full_done");

    // Backpressure holds the current beat.
    bus.out_ready = 1'b0;
    accept(8'h0A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      beat("stall", 3'd1, 1'b0, 1'b0);
    end
    bus.out_ready = 1'b1;
    beat("unstall0", 3'd1, 1'b0, 1'b0);
    beat("unstall1", 3'd3, 1'b1, 1'b0);
    check_idle("unstall_done");

    // Reset mid-drain discards the rest.
    accept(8'hF0, 1'b0);
    beat("rst_first", 3'd4, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_mid");
    tick();
    check_idle("rst_quiet");
    accept(8'h01, 1'b0);
    beat("after_rst", 3'd0, 1'b1, 1'b0);
    check_idle("after_rst_done");

    // Reset beats a simultaneous input handshake.
    bus.in_vec   = 8'h81;
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("rst_vs_in");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
